// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Arbitrates I-cache line fills and D-cache fills/write-backs onto one
//   shared downstream (L2) port. A request is granted from IDLE only. The
//   granted address, operation and write data are latched, then held on the
//   L2 strobes until l2_resp. A one-cycle completion pulse then goes back to
//   the granted side from DONE. All outputs are registered.
//
// Parameters
//   LINE_WIDTH : cache-line width in bits for all line data ports
//   FAIR       : 1 = round-robin when both sides request, 0 = D-side always wins
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   i_pmem_read/address        : I-cache fill request and line address
//   i_pmem_rdata/resp          : line returned to I-cache, completion pulse
//   d_pmem_read/write/address  : D-cache fill / write-back request and address
//   d_pmem_wdata               : write-back line
//   d_pmem_rdata/resp          : line returned to D-cache, completion pulse
//   l2_read/write/address/wdata: downstream request (registered)
//   l2_rdata/resp              : downstream read data and completion
module cache_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [15:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [15:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [15:0]           l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  // Side granted most recently: 1 = D, 0 = I. It also identifies the side
  // being served, because it is updated on every grant.
  logic                  last_grant_q, last_grant_d;
  logic                  l2_read_q, l2_read_d;
  logic                  l2_write_q, l2_write_d;
  logic [15:0]           l2_address_q, l2_address_d;
  logic [LINE_WIDTH-1:0] l2_wdata_q, l2_wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_resp_q, i_resp_d;
  logic                  d_resp_q, d_resp_d;

  logic                  i_req;
  logic                  d_req;
  logic                  pick_d;

  // Arbitration decision, only consumed in IDLE.
  always_comb begin
    i_req  = i_pmem_read;
    d_req  = d_pmem_read | d_pmem_write;
    pick_d = 1'b0;
    if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (d_req && i_req) begin
      // Tie: round-robin grants whichever side did not win last time.
      pick_d = FAIR ? ~last_grant_q : 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = pick_d;
          if (pick_d) begin
            state_d      = SERVE_D;
            l2_address_d = d_pmem_address;
            // Read and write both high is treated as a write-back.
            l2_write_d   = d_pmem_write;
            l2_read_d    = ~d_pmem_write;
            if (d_pmem_write) begin
              l2_wdata_d = d_pmem_wdata;
            end
          end else begin
            state_d      = SERVE_I;
            l2_address_d = i_pmem_address;
            l2_read_d    = 1'b1;
            l2_write_d   = 1'b0;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d    = DONE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          // Completion pulse is registered, so it appears during DONE.
          if (state_q == SERVE_I) begin
            i_rdata_d = l2_rdata;
            i_resp_d  = 1'b1;
          end else begin
            if (l2_read_q) begin
              d_rdata_d = l2_rdata;
            end
            d_resp_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

  assign l2_read      = l2_read_q;
  assign l2_write     = l2_write_q;
  assign l2_address   = l2_address_q;
  assign l2_wdata     = l2_wdata_q;
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_resp  = d_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter. Instance u_fair (FAIR=1) is the main target.
// Its downstream responds after a programmable number of strobe cycles.
// Instance u_fixed (FAIR=0) shares the requester inputs. Its downstream
// answers in the first strobe cycle, and it is used for the fixed-priority
// check.
module tb_cache_arbiter;

  localparam int LW = 128;

  typedef struct {
    bit          side_d;
    bit          is_wr;
    logic [15:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0;
  logic [15:0]   i_addr = '0;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [15:0]   d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] l2_rdata = '0;

  logic [LW-1:0] i_rdata0, d_rdata0, l2_wdata0;
  logic          i_resp0, d_resp0, l2_read0, l2_write0, l2_resp0;
  logic [15:0]   l2_addr0;
  logic [LW-1:0] i_rdata1, d_rdata1, l2_wdata1;
  logic          i_resp1, d_resp1, l2_read1, l2_write1, l2_resp1;
  logic [15:0]   l2_addr1;

  logic          model_resp = 1'b0;
  logic          stray_resp = 1'b0;
  int            resp_after = 1;
  int            serve_cnt = 0;

  exp_t          sb[$];
  bit            grants1[$];
  exp_t          cur;
  logic [LW-1:0] got;
  int            vectors = 0;
  int            errors = 0;

  assign l2_resp0 = model_resp | stray_resp;
  assign l2_resp1 = l2_read1 | l2_write1;

  cache_arbiter #(.LINE_WIDTH(LW), .FAIR(1'b1)) u_fair (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(i_rdata0), .i_pmem_resp(i_resp0),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata0), .d_pmem_resp(d_resp0),
    .l2_read(l2_read0), .l2_write(l2_write0), .l2_address(l2_addr0),
    .l2_wdata(l2_wdata0), .l2_rdata(l2_rdata), .l2_resp(l2_resp0)
  );

  cache_arbiter #(.LINE_WIDTH(LW), .FAIR(1'b0)) u_fixed (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(i_rdata1), .i_pmem_resp(i_resp1),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata1), .d_pmem_resp(d_resp1),
    .l2_read(l2_read1), .l2_write(l2_write1), .l2_address(l2_addr1),
    .l2_wdata(l2_wdata1), .l2_rdata(l2_rdata), .l2_resp(l2_resp1)
  );

  always #5 clk = ~clk;

  // Downstream model for u_fair: respond in the resp_after-th strobe cycle.
  always @(negedge clk) begin
    if (l2_read0 || l2_write0) begin
      serve_cnt  = serve_cnt + 1;
      model_resp = (serve_cnt == resp_after);
    end else begin
      serve_cnt  = 0;
      model_resp = 1'b0;
    end
  end

  // Scoreboard monitor for u_fair plus protocol invariants.
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      if (i_resp0 && d_resp0) begin
        errors++;
        $display("FAIL resp_exclusive: i_resp=%b d_resp=%b, required not both", i_resp0, d_resp0);
      end
      vectors++;
      if (l2_read0 && l2_write0) begin
        errors++;
        $display("FAIL strobe_exclusive: l2_read=%b l2_write=%b, required not both", l2_read0, l2_write0);
      end
      if (l2_read0 || l2_write0) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: addr=%h with no transaction pending", l2_addr0);
        end else if (l2_addr0 !== sb[0].addr || l2_write0 !== sb[0].is_wr) begin
          errors++;
          $display("FAIL l2_request: addr=%h write=%b, required addr=%h write=%b",
                   l2_addr0, l2_write0, sb[0].addr, sb[0].is_wr);
        end else if (sb[0].is_wr && l2_wdata0 !== sb[0].wdata) begin
          errors++;
          $display("FAIL l2_wdata: got %h, required %h", l2_wdata0, sb[0].wdata);
        end
      end
      if (i_resp0 || d_resp0) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: i_resp=%b d_resp=%b with nothing pending", i_resp0, d_resp0);
        end else begin
          cur = sb.pop_front();
          got = cur.side_d ? d_rdata0 : i_rdata0;
          if (d_resp0 !== cur.side_d) begin
            errors++;
            $display("FAIL resp_side: d_resp=%b, required %b", d_resp0, cur.side_d);
          end else if (got !== cur.rdata) begin
            errors++;
            $display("FAIL resp_rdata: got %h, required %h", got, cur.rdata);
          end else begin
            $display("txn %s %s addr=%h ok", cur.side_d ? "D" : "I", cur.is_wr ? "WR" : "RD", cur.addr);
          end
        end
      end
    end
  end

  // Grant log for u_fixed, taken from its completion pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_resp1) grants1.push_back(1'b0);
      if (d_resp1) grants1.push_back(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until u_fair pulses a resp (bounded). With drop=1 the requester
  // withdraws and scrambles its address/data right after the grant edge.
  task automatic wait_resp(input bit drop, output int edges, output int strobes);
    edges   = 0;
    strobes = 0;
    do begin
      tick();
      edges++;
      if (drop && edges == 1) begin
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        i_addr  = ~i_addr;
        d_addr  = ~d_addr;
        d_wdata = ~d_wdata;
      end
      if (l2_read0 || l2_write0) strobes++;
    end while (!(i_resp0 || d_resp0) && edges < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({l2_read0, l2_write0, i_resp0, d_resp0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd/wr/iresp/dresp=%b, required 0000", {l2_read0, l2_write0, i_resp0, d_resp0});
    end
    vectors++;
    if (l2_addr0 !== 16'h0 || l2_wdata0 !== '0) begin
      errors++;
      $display("FAIL reset_l2: addr=%h wdata=%h, required 0", l2_addr0, l2_wdata0);
    end
    vectors++;
    if (i_rdata0 !== '0 || d_rdata0 !== '0) begin
      errors++;
      $display("FAIL reset_rdata: i=%h d=%h, required 0", i_rdata0, d_rdata0);
    end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_i_read(input logic [LW-1:0] line);
    int edges, strobes;
    resp_after = 2;
    l2_rdata   = line;
    sb.push_back('{1'b0, 1'b0, 16'h1230, '0, line});
    i_addr = 16'h1230;
    i_read = 1'b1;
    wait_resp(1'b1, edges, strobes);
    vectors++;
    if (edges !== 3 || strobes !== 2) begin
      errors++;
      $display("FAIL i_read_timing: edges=%0d strobes=%0d, required 3 and 2", edges, strobes);
    end
    tick();
    vectors++;
    if (i_resp0 !== 1'b0 || i_rdata0 !== line) begin
      errors++;
      $display("FAIL i_read_pulse: resp=%b rdata=%h, required 0 and %h", i_resp0, i_rdata0, line);
    end
  endtask

  task automatic test_d_read(input logic [LW-1:0] line, input logic [LW-1:0] i_line);
    int edges, strobes;
    resp_after = 1;
    l2_rdata   = line;
    sb.push_back('{1'b1, 1'b0, 16'h2040, '0, line});
    d_addr = 16'h2040;
    d_read = 1'b1;
    wait_resp(1'b1, edges, strobes);
    vectors++;
    if (edges !== 2) begin
      errors++;
      $display("FAIL d_read_latency: edges=%0d, required 2", edges);
    end
    tick();
    vectors++;
    if (d_rdata0 !== line || i_rdata0 !== i_line) begin
      errors++;
      $display("FAIL d_read_hold: d=%h i=%h, required %h %h", d_rdata0, i_rdata0, line, i_line);
    end
  endtask

  task automatic test_d_write(input bit both, input logic [15:0] addr,
                              input logic [LW-1:0] w, input logic [LW-1:0] d_line);
    int edges, strobes;
    resp_after = 1;
    l2_rdata   = ~d_line;
    sb.push_back('{1'b1, 1'b1, addr, w, d_line});
    d_addr  = addr;
    d_wdata = w;
    d_write = 1'b1;
    d_read  = both;
    wait_resp(1'b1, edges, strobes);
    vectors++;
    if (edges !== 2 || strobes !== 1) begin
      errors++;
      $display("FAIL d_write_timing: edges=%0d strobes=%0d, required 2 and 1", edges, strobes);
    end
    tick();
    vectors++;
    if (d_resp0 !== 1'b0 || d_rdata0 !== d_line) begin
      errors++;
      $display("FAIL d_write_rdata: resp=%b rdata=%h, required 0 and %h", d_resp0, d_rdata0, d_line);
    end
  endtask

  task automatic test_addr_change(input logic [LW-1:0] line);
    int edges, strobes;
    resp_after = 3;
    l2_rdata   = line;
    sb.push_back('{1'b0, 1'b0, 16'h1111, '0, line});
    i_addr = 16'h1111;
    i_read = 1'b1;
    wait_resp(1'b1, edges, strobes);
    vectors++;
    if (edges !== 4 || strobes !== 3 || i_resp0 !== 1'b1) begin
      errors++;
      $display("FAIL addr_change: edges=%0d strobes=%0d resp=%b, required 4 3 1", edges, strobes, i_resp0);
    end
    tick();
  endtask

  task automatic test_stray_resp();
    stray_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({l2_read0, l2_write0, i_resp0, d_resp0} !== 4'b0) begin
        errors++;
        $display("FAIL stray_resp: rd/wr/iresp/dresp=%b, required 0000", {l2_read0, l2_write0, i_resp0, d_resp0});
      end
    end
    stray_resp = 1'b0;
    $display("stray l2_resp ignored check done");
  endtask

  task automatic test_fairness(input logic [LW-1:0] line);
    int edges, strobes;
    reset = 1'b1;
    tick();
    tick();
    resp_after = 1;
    l2_rdata   = line;
    i_addr = 16'h0A00;
    d_addr = 16'h0D00;
    i_read = 1'b1;
    d_read = 1'b1;
    grants1.delete();
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{k[0], 1'b0, k[0] ? 16'h0D00 : 16'h0A00, '0, line});
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_resp(1'b0, edges, strobes);
      vectors++;
      if (d_resp0 !== k[0] || edges !== (k == 0 ? 2 : 3)) begin
        errors++;
        $display("FAIL fair_grant%0d: d_resp=%b edges=%0d, required %b and %0d",
                 k, d_resp0, edges, k[0], (k == 0 ? 2 : 3));
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    tick();
    vectors++;
    if (grants1.size() != 4) begin
      errors++;
      $display("FAIL fixed_count: %0d grants, required 4", grants1.size());
    end
    for (int k = 0; k < grants1.size() && k < 3; k++) begin
      vectors++;
      if (grants1[k] !== 1'b1) begin
        errors++;
        $display("FAIL fixed_grant%0d: side_d=%b, required 1", k, grants1[k]);
      end
    end
    vectors++;
    if (d_rdata1 !== line || i_rdata1 !== '0 || l2_wdata1 !== '0 || l2_addr1 !== 16'h0D00) begin
      errors++;
      $display("FAIL fixed_state: d=%h i=%h wdata=%h addr=%h", d_rdata1, i_rdata1, l2_wdata1, l2_addr1);
    end
    $display("fairness: fixed-priority grants logged=%0d", grants1.size());
  endtask

  task automatic test_reset_mid(input logic [LW-1:0] line);
    int edges, strobes;
    resp_after = 100;
    sb.push_back('{1'b1, 1'b0, 16'h3000, '0, '0});
    d_addr = 16'h3000;
    d_read = 1'b1;
    tick();
    d_read = 1'b0;
    vectors++;
    if (l2_read0 !== 1'b1 || l2_addr0 !== 16'h3000) begin
      errors++;
      $display("FAIL reset_mid_serve: l2_read=%b addr=%h, required 1 3000", l2_read0, l2_addr0);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    vectors++;
    if ({l2_read0, l2_write0, i_resp0, d_resp0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: rd/wr/iresp/dresp=%b, required 0000", {l2_read0, l2_write0, i_resp0, d_resp0});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (d_resp0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_noresp: d_resp=%b, required 0", d_resp0);
      end
    end
    resp_after = 1;
    l2_rdata   = line;
    sb.push_back('{1'b0, 1'b0, 16'h5550, '0, line});
    i_addr = 16'h5550;
    i_read = 1'b1;
    wait_resp(1'b1, edges, strobes);
    vectors++;
    if (edges !== 2 || i_resp0 !== 1'b1 || i_rdata0 !== line) begin
      errors++;
      $display("FAIL reset_mid_after: edges=%0d resp=%b rdata=%h, required 2 1 %h", edges, i_resp0, i_rdata0, line);
    end
    tick();
  endtask

  initial begin
    logic [LW-1:0] a5_line, d_line, w_line, w2_line, c_line, f_line, r_line;
    a5_line = {16{8'hA5}};
    d_line  = {$urandom, $urandom, $urandom, $urandom};
    w_line  = {$urandom, $urandom, $urandom, $urandom};
    w2_line = {$urandom, $urandom, $urandom, $urandom};
    c_line  = {$urandom, $urandom, $urandom, $urandom};
    f_line  = {$urandom, $urandom, $urandom, $urandom};
    r_line  = {$urandom, $urandom, $urandom, $urandom};

    test_reset();
    tick();
    test_i_read(a5_line);
    test_d_read(d_line, a5_line);
    test_d_write(1'b0, 16'h4400, w_line, d_line);
    test_d_write(1'b1, 16'h0800, w2_line, d_line);
    test_addr_change(c_line);
    test_stray_resp();
    test_fairness(f_line);
    test_reset_mid(r_line);

    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transactions never completed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
